// File: rtl/apb4_master_bridge.sv
// -----------------------------------------------------------------------------
// apb4_master_bridge
//
// Converts a simple valid/ready command port into APB4 requester transfers and
// returns completion status on a valid/ready response port. Only one transfer
// is in flight at a time. Each command is carried out as one SETUP cycle and
// then an ACCESS phase. The ACCESS phase lasts until PREADY is high, or until
// the wait-state counter reaches TIMEOUT, in which case the transfer is aborted.
//
// Every output comes from a flop. The next-value logic looks at the next FSM
// state, so no input reaches cmd_ready or any APB output combinationally.
//
// Ports
//   clk, rst_b          clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake (ready is high only in IDLE)
//   cmd_write           1 = write, 0 = read
//   cmd_addr/wdata      transfer address / write data
//   cmd_strb, cmd_prot  write byte strobes / protection attributes
//   rsp_valid/ready     response handshake
//   rsp_rdata           read data (0 for writes and timeouts)
//   rsp_err             PSLVERR seen, or timeout
//   rsp_timeout         transfer aborted by the wait-state limit
//   PADDR..PSTRB        APB4 requester outputs
//   PRDATA, PREADY,
//   PSLVERR             APB4 completer inputs
// -----------------------------------------------------------------------------
module apb4_master_bridge #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    input  logic [2:0]            cmd_prot,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_W-1:0]     PADDR,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_W-1:0]     PWDATA,
    output logic [2:0]            PPROT,
    output logic [DATA_W/8-1:0]   PSTRB,
    input  logic [DATA_W-1:0]     PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int STRB_W = DATA_W / 8;

    // The counter holds the number of PREADY-low ACCESS cycles already seen.
    // The abort happens in the cycle that makes the count reach TIMEOUT.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] wait_cnt;

    logic        accept;
    logic        done;
    logic        abort;
    logic        rsp_hs;

    logic        cmd_ready_d;
    logic        psel_d;
    logic        penable_d;
    logic        rsp_valid_d;

    assign accept = cmd_valid && cmd_ready;
    // A completion in the same cycle as the last permitted wait state has
    // priority over the abort.
    assign done   = (state == ACCESS) && PREADY;
    assign abort  = (state == ACCESS) && !PREADY && (wait_cnt == WAIT_LAST);
    assign rsp_hs = rsp_valid && rsp_ready;

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:   if (accept)         next_state = SETUP;
            SETUP:                      next_state = ACCESS;
            ACCESS: if (done || abort)  next_state = RESP;
            RESP:   if (rsp_hs)         next_state = IDLE;
            default:                    next_state = IDLE;
        endcase
    end

    // Output decode. Each value is derived from the next state, so the
    // registered outputs line up with the state they describe.
    always_comb begin
        cmd_ready_d = (next_state == IDLE);
        psel_d      = (next_state == SETUP) || (next_state == ACCESS);
        penable_d   = (next_state == ACCESS);
        rsp_valid_d = (next_state == RESP);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cmd_ready <= 1'b1;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            cmd_ready <= cmd_ready_d;
            PSELx     <= psel_d;
            PENABLE   <= penable_d;
            rsp_valid <= rsp_valid_d;
        end
    end

    // Request fields are captured once, at accept, and then held for the
    // whole transfer. The strobes are forced to zero for reads.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
            PPROT  <= '0;
            PSTRB  <= '0;
        end else if (accept) begin
            PADDR  <= cmd_addr;
            PWRITE <= cmd_write;
            PWDATA <= cmd_wdata;
            PPROT  <= cmd_prot;
            PSTRB  <= cmd_write ? cmd_strb : {STRB_W{1'b0}};
        end
    end

    // Response fields are loaded when ACCESS ends. They stay unchanged
    // through RESP until the response handshake.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (done) begin
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
        end else if (abort) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
        end
    end

    // Wait-state counter
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wait_cnt <= '0;
        end else if (state == RESP && rsp_hs) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !PREADY) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

endmodule

// File: doc/apb4_master_bridge.md
Name: apb4_master_bridge

Overview:
- Simple request/response command port to APB4 requester (initiator) bridge; drives the 12-bit/32-bit APB4 register blocks from a sequencer, debug port or CPU-side fabric.
- One transfer in flight; each command becomes a SETUP phase followed by an ACCESS phase. The ACCESS phase extends on PREADY wait states.
- Returns read data, slave error and timeout status on a valid/ready response channel.

Parameters:
- ADDR_W, 12, APB address width.
- DATA_W, 32, APB data width; PSTRB width is DATA_W/8.
- TIMEOUT, 255, maximum ACCESS-phase cycles with PREADY low before abort; range 1..65535.

Ports:
- clk  input  1  clock
- rst_b  input  1  reset, asynchronous, active-low
- cmd_valid  input  1  command present
- cmd_ready  output  1  bridge accepts command
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  ADDR_W  transfer address
- cmd_wdata  input  DATA_W  write data
- cmd_strb  input  DATA_W/8  write byte strobes
- cmd_prot  input  3  PPROT value
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_rdata  output  DATA_W  read data; 0 for writes and timeouts
- rsp_err  output  1  PSLVERR seen, or timeout
- rsp_timeout  output  1  transfer aborted by timeout
- PADDR  output  ADDR_W
- PSELx  output  1
- PENABLE  output  1
- PWRITE  output  1
- PWDATA  output  DATA_W
- PPROT  output  3
- PSTRB  output  DATA_W/8
- PRDATA  input  DATA_W
- PREADY  input  1
- PSLVERR  input  1

Behaviour:
- Reset values: all outputs 0, except cmd_ready=1. FSM in IDLE, timeout counter 0.
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB outputs and rsp_* outputs are registered.
- IDLE:
  - cmd_ready=1, PSELx=0, PENABLE=0.
  - On cmd_valid&&cmd_ready, capture the command into PADDR, PWRITE, PWDATA, PPROT and PSTRB, then go to SETUP.
  - PSTRB is forced to 0 when cmd_write=0.
- SETUP (exactly 1 cycle):
  - PSELx=1, PENABLE=0, cmd_ready=0. Go to ACCESS.
- ACCESS:
  - PSELx=1, PENABLE=1.
  - PADDR, PWRITE, PWDATA, PPROT and PSTRB hold stable from SETUP until the transfer ends.
  - On the first cycle with PREADY=1:
    - Sample PSLVERR into rsp_err.
    - Sample PRDATA into rsp_rdata if reading; else rsp_rdata=0.
    - Set rsp_timeout=0, drop PSELx/PENABLE the next cycle, go to RESP.
  - PSLVERR is ignored when PREADY=0.
  - The counter increments every ACCESS cycle with PREADY=0. When it reaches TIMEOUT with PREADY still 0:
    - Abort: drop PSELx/PENABLE the next cycle, set rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
  - If PREADY=1 arrives on the same cycle the counter reaches TIMEOUT, the completion wins: normal response, no timeout.
- RESP:
  - rsp_valid=1 and the rsp_* fields hold stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid=0, cmd_ready=1, counter cleared, go to IDLE.
- Latency:
  - Command accepted at cycle N → SETUP at N+1 → ACCESS at N+2.
  - With PREADY=1 at N+2, rsp_valid rises at N+3.
  - Minimum 4 cycles between accepted commands when rsp_ready is held high.
- cmd_* inputs are ignored outside the IDLE accept cycle.
- No combinational path from any input to cmd_ready or to the APB outputs.
- Reset mid-transfer: asynchronous return to the reset values. PSELx/PENABLE drop immediately and any pending response is discarded.

Test Plan:
- Write 0x004 = 0x12345678, strb=0xF, prot=0, PREADY tied 1.
  - Required: SETUP with PSELx=1/PENABLE=0, then one ACCESS cycle with PADDR=0x004, PWDATA=0x12345678, PSTRB=0xF.
  - Required: rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read 0x400 with PREADY low for 3 ACCESS cycles, PRDATA=0xCAFEF00D on the ready cycle.
  - Required: ACCESS lasts 4 cycles with PADDR and controls stable, PSTRB=0.
  - Required: rsp_rdata=0xCAFEF00D, rsp_err=0.
- Read 0xFF0, slave returns PREADY=1 with PSLVERR=1.
  - Required: rsp_err=1, rsp_timeout=0.
  - Required: a PSLVERR pulse during an earlier PREADY=0 cycle is ignored.
- TIMEOUT=8, PREADY held 0.
  - Required: abort after 8 ACCESS cycles, rsp_err=1, rsp_timeout=1, PSELx=0 the following cycle.
  - Repeat with PREADY=1 on the 8th cycle: normal completion, rsp_timeout=0.
- rsp_ready held low 5 cycles after a read completes.
  - Required: rsp_valid and rsp_rdata stable, cmd_ready=0, a new cmd_valid not accepted.
  - Required: the next command is accepted the cycle after the rsp handshake.
- Assert rst_b low during ACCESS.
  - Required: PSELx, PENABLE and rsp_valid go 0 immediately, cmd_ready=1 after release, a new write completes normally.
